// File: rtl/serial_deserializer_pkg.sv
// Shared definitions for the serial deserializer.
// Holds the FSM state encoding, the default word width and the frame
// marker bit values used by both the controller and the datapath.
package serial_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Frame markers: a frame opens with a 1 and closes with a 0.
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // 2-bit state encoding; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_STOP  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_deserializer_if.sv
// Word-side and serial-side signal bundle of the serial deserializer.
//   d, en, ready          : driven by the producer/consumer (master)
//   q, valid, busy,
//   frame_err, overrun    : driven by the deserializer (slave)
interface serial_deserializer_if #(
  parameter int WIDTH = serial_deserializer_pkg::DEFAULT_WIDTH
);
  logic             d;
  logic             en;
  logic             ready;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    output d, en, ready,
    input  q, valid, busy, frame_err, overrun
  );

  modport slave (
    input  d, en, ready,
    output q, valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/serial_deserializer_ctrl.sv
// Frame-sequencing FSM and data-bit counter of the serial deserializer.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   en, d       : sample enable and sampled serial bit
//   shift_en    : comb, shift d into the shift register this edge
//   load_req    : comb, valid stop bit sampled this edge (word complete)
//   frame_err   : registered one-cycle pulse, stop bit sampled as 1
//   busy        : registered, frame reception in progress
module serial_deserializer_ctrl
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic shift_en,
  output logic load_req,
  output logic frame_err,
  output logic busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          frame_err_n;

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      // busy tracks the state actually entered, so it is a clean flop output.
      busy      <= (state_n != ST_IDLE);
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    shift_en    = 1'b0;
    load_req    = 1'b0;
    frame_err_n = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (en && d == START_BIT) begin
          state_n = ST_SHIFT;
          cnt_n   = '0;
        end
      end

      ST_SHIFT: begin
        if (en) begin
          shift_en = 1'b1;
          // Counter saturates at the last bit index rather than wrapping.
          if (cnt == LAST_BIT) state_n = ST_STOP;
          else                 cnt_n   = cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (en) begin
          state_n = ST_IDLE;
          if (d == STOP_BIT) load_req    = 1'b1;
          else               frame_err_n = 1'b1;
        end
      end

      // Unused encoding: recover unconditionally, independent of en.
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial deserializer: assembles start/data(LSB-first)/stop frames from a
// 1-bit stream into WIDTH-bit words, presented via valid/ready.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of serial_deserializer_if
//           (d, en, ready in; q, valid, busy, frame_err, overrun out)
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_deserializer_if.slave bus
);

  logic             shift_en;
  logic             load_req;
  logic [WIDTH-1:0] sreg;
  logic             load;
  logic             drop;

  serial_deserializer_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .en        (bus.en),
    .d         (bus.d),
    .shift_en  (shift_en),
    .load_req  (load_req),
    .frame_err (bus.frame_err),
    .busy      (bus.busy)
  );

  // A completed word is accepted if the output slot is empty or is being
  // consumed on this same edge; otherwise it is dropped and flagged.
  assign load = load_req && (!bus.valid || bus.ready);
  assign drop = load_req &&   bus.valid && !bus.ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shift register is reset too; it is a handful of flops,
      // and a known value keeps q deterministic after any reset.
      sreg        <= '0;
      bus.q       <= '0;
      bus.valid   <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (shift_en) sreg <= {bus.d, sreg[WIDTH-1:1]};

      if (load) begin
        bus.q     <= sreg;
        bus.valid <= 1'b1;
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end

      // Sticky until reset.
      if (drop) bus.overrun <= 1'b1;
    end
  end

endmodule
